therm_encoder_15: RTL and testbench

Converts the 15-bit thermometer code from the flash comparator bank into a 4-bit binary sample, the receive-side counterpart of the binary-to-thermometer decoder that drives the unary DAC elements. Comparator outputs are asynchronous. The block synchronizes them, captures a sample on a strobe, optionally repairs single-bit bubbles, encodes the code to binary and presents the result on a valid/ready output. Error and drop statistics go to the control logic.

---
 rtl/therm_pkg.sv | 50 +++++
 rtl/therm_encoder_15_if.sv | 31 +++
 rtl/therm_sync.sv | 29 ++
 rtl/therm_encoder_15.sv | 105 ++++++++++
 tb/tb_therm_encoder_15.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/therm_pkg.sv
// Shared types and helpers for the 15-level thermometer-to-binary encoder.
// Covers bubble detection, majority repair and the popcount encode.
package therm_pkg;

    localparam int THERM_W = 15;
    localparam int BIN_W   = 4;
    localparam int CNT_W   = 8;

    typedef logic [THERM_W-1:0] therm_t;
    typedef logic [BIN_W-1:0]   bin_t;
    typedef logic [CNT_W-1:0]   cnt_t;

    // A bubble is any 0 sitting directly below a 1.
    function automatic logic has_bubble(input therm_t t);
        logic b;
        b = 1'b0;
        for (int i = 0; i < THERM_W - 1; i++) begin
            b = b | (~t[i] & t[i+1]);
        end
        return b;
    endfunction

    // Three-input majority per bit; the code is padded with a 1 below bit 0
    // and a 0 above the top bit.
    function automatic therm_t majority_fix(input therm_t t);
        logic [THERM_W+1:0] ext;
        therm_t             c;
        ext = {1'b0, t, 1'b1};
        c   = '0;
        for (int i = 0; i < THERM_W; i++) begin
            c[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
        end
        return c;
    endfunction

    // Fifteen ones is the largest input, so a 4-bit sum cannot overflow.
    function automatic bin_t popcount(input therm_t t);
        bin_t s;
        s = '0;
        for (int i = 0; i < THERM_W; i++) begin
            s = s + bin_t'(t[i]);
        end
        return s;
    endfunction

    function automatic cnt_t sat_inc(input cnt_t c);
        return (c == '1) ? c : c + cnt_t'(1);
    endfunction

endpackage

// File: rtl/therm_encoder_15_if.sv
// Comparator-input and valid/ready output bundle for therm_encoder_15.
// The master side drives the code, strobe and ready; the slave side is the encoder.
interface therm_encoder_15_if;
    import therm_pkg::*;

    therm_t therm_in;
    logic   sample_en;
    logic   out_ready;
    logic   out_valid;
    bin_t   bin_out;
    logic   bubble_flag;

    modport master (
        output therm_in,
        output sample_en,
        output out_ready,
        input  out_valid,
        input  bin_out,
        input  bubble_flag
    );

    modport slave (
        input  therm_in,
        input  sample_en,
        input  out_ready,
        output out_valid,
        output bin_out,
        output bubble_flag
    );

endinterface

// File: rtl/therm_sync.sv
// SYNC_STAGES-deep flop chain bringing the asynchronous comparator code into clk.
// Legal depth is 2..4; the last flop is the synchronized output.
module therm_sync
    import therm_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic   clk,
    input  logic   rst,
    input  therm_t d_i,
    output therm_t q_o
);

    logic [SYNC_STAGES-1:0][THERM_W-1:0] stg_q;
    logic [SYNC_STAGES-1:0][THERM_W-1:0] stg_d;

    assign stg_d = {stg_q[SYNC_STAGES-2:0], d_i};

    always_ff @(posedge clk) begin
        if (rst) begin
            stg_q <= '0;
        end else begin
            stg_q <= stg_d;
        end
    end

    assign q_o = stg_q[SYNC_STAGES-1];

endmodule

// File: rtl/therm_encoder_15.sv
// Thermometer-to-binary encoder: sync, capture, optional bubble repair, popcount, valid/ready out.
// Build option: define THERM_ENC_BUBBLE_CORRECT_EN to apply majority repair before encoding.
module therm_encoder_15
    import therm_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    therm_encoder_15_if.slave        bus,
    output cnt_t                     err_cnt,
    output cnt_t                     drop_cnt
);

    therm_t t_sync;

    therm_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (bus.therm_in),
        .q_o (t_sync)
    );

    therm_t t1_q,   t1_d;
    logic   v1_q,   v1_d;
    logic   ov_q,   ov_d;
    bin_t   bin_q,  bin_d;
    logic   bub_q,  bub_d;
    cnt_t   err_q,  err_d;
    cnt_t   drop_q, drop_d;

    logic   adv, accept, drop, xfer, bubble;
    therm_t corr;
    bin_t   enc;

    assign adv    = v1_q && (!ov_q || bus.out_ready);
    assign accept = !v1_q || adv;
    assign drop   = bus.sample_en && !accept;
    assign xfer   = ov_q && bus.out_ready;

    // Bubble detection always looks at the raw capture, whichever build this is.
    assign bubble = has_bubble(t1_q);
`ifdef THERM_ENC_BUBBLE_CORRECT_EN
    assign corr = majority_fix(t1_q);
`else
    assign corr = t1_q;
`endif
    assign enc = popcount(corr);

    always_comb begin
        t1_d   = t1_q;
        v1_d   = v1_q;
        ov_d   = ov_q;
        bin_d  = bin_q;
        bub_d  = bub_q;
        err_d  = err_q;
        drop_d = drop_q;

        if (bus.sample_en && accept) begin
            t1_d = t_sync;
            v1_d = 1'b1;
        end else if (adv) begin
            v1_d = 1'b0;
        end

        // A load in the same cycle as a transfer overwrites the departing sample.
        if (adv) begin
            bin_d = enc;
            bub_d = bubble;
            ov_d  = 1'b1;
            if (bubble) err_d = sat_inc(err_q);
        end else if (xfer) begin
            ov_d = 1'b0;
        end

        if (drop) drop_d = sat_inc(drop_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            t1_q   <= '0;
            v1_q   <= 1'b0;
            ov_q   <= 1'b0;
            bin_q  <= '0;
            bub_q  <= 1'b0;
            err_q  <= '0;
            drop_q <= '0;
        end else begin
            t1_q   <= t1_d;
            v1_q   <= v1_d;
            ov_q   <= ov_d;
            bin_q  <= bin_d;
            bub_q  <= bub_d;
            err_q  <= err_d;
            drop_q <= drop_d;
        end
    end

    assign bus.out_valid   = ov_q;
    assign bus.bin_out     = bin_q;
    assign bus.bubble_flag = bub_q;
    assign err_cnt         = err_q;
    assign drop_cnt        = drop_q;

endmodule

// File: tb/tb_therm_encoder_15.sv
// Directed bench for therm_encoder_15 with hand-computed expectations.
// Expected bubble results follow THERM_ENC_BUBBLE_CORRECT_EN when it is defined.
module tb_therm_encoder_15;
    import therm_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    cnt_t err_cnt, drop_cnt;
    int   n_cmp = 0;
    int   n_err = 0;

    therm_encoder_15_if ifc ();

    therm_encoder_15 #(.SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (ifc.slave),
        .err_cnt  (err_cnt),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a code, let it cross the synchronizer, then strobe once.
    task automatic send(input therm_t v);
        ifc.therm_in = v;
        step();
        step();
        ifc.sample_en = 1'b1;
        step();
        ifc.sample_en = 1'b0;
    endtask

    initial begin
        ifc.therm_in  = '0;
        ifc.sample_en = 1'b0;
        ifc.out_ready = 1'b0;
        repeat (3) step();
        chk("rst_valid", ifc.out_valid, 0);
        chk("rst_bin",   ifc.bin_out, 0);
        chk("rst_bub",   ifc.bubble_flag, 0);
        chk("rst_err",   err_cnt, 0);
        chk("rst_drop",  drop_cnt, 0);
        rst = 1'b0;
        ifc.out_ready = 1'b1;

        // Clean code, latency: valid appears one edge after the capture edge.
        send(15'h007F);
        chk("lat_n", ifc.out_valid, 0);
        step();
        chk("lat_n1",    ifc.out_valid, 1);
        chk("clean_bin", ifc.bin_out, 7);
        chk("clean_bub", ifc.bubble_flag, 0);
        step();
        chk("clean_gone", ifc.out_valid, 0);

        send(15'h7FFF);
        step();
        chk("full_bin", ifc.bin_out, 15);
        chk("full_bub", ifc.bubble_flag, 0);

        send(15'h0000);
        step();
        chk("zero_valid", ifc.out_valid, 1);
        chk("zero_bin",   ifc.bin_out, 0);
        chk("zero_bub",   ifc.bubble_flag, 0);
        chk("zero_err",   err_cnt, 0);

        send(15'h007B);
        step();
`ifdef THERM_ENC_BUBBLE_CORRECT_EN
        chk("bub_bin", ifc.bin_out, 7);
`else
        chk("bub_bin", ifc.bin_out, 6);
`endif
        chk("bub_flag", ifc.bubble_flag, 1);
        chk("bub_err",  err_cnt, 1);

        // Lone top bit: bubble at the upper boundary.
        send(15'h4000);
        step();
`ifdef THERM_ENC_BUBBLE_CORRECT_EN
        chk("top_bin", ifc.bin_out, 0);
`else
        chk("top_bin", ifc.bin_out, 1);
`endif
        chk("top_flag", ifc.bubble_flag, 1);
        chk("top_err",  err_cnt, 2);
        step();

        // Backpressure: two held, third dropped.
        ifc.out_ready = 1'b0;
        send(15'h0007);
        step();
        chk("bp_v1",  ifc.out_valid, 1);
        chk("bp_b1",  ifc.bin_out, 3);
        send(15'h001F);
        send(15'h01FF);
        chk("bp_drop", drop_cnt, 1);
        step();
        step();
        chk("bp_hold", ifc.bin_out, 3);
        chk("bp_hold_v", ifc.out_valid, 1);
        ifc.out_ready = 1'b1;
        step();
        chk("bp_v2",  ifc.out_valid, 1);
        chk("bp_b2",  ifc.bin_out, 5);
        step();
        chk("bp_empty", ifc.out_valid, 0);
        chk("bp_drop_kept", drop_cnt, 1);

        // Error counter saturation at full throughput.
        ifc.therm_in = 15'h007B;
        step();
        step();
        ifc.sample_en = 1'b1;
        repeat (300) step();
        ifc.sample_en = 1'b0;
        repeat (3) step();
        chk("err_sat", err_cnt, 255);
        chk("tput_nodrop", drop_cnt, 1);

        // Drop counter saturation under a stall; leaves two samples buffered.
        ifc.out_ready = 1'b0;
        ifc.sample_en = 1'b1;
        repeat (302) step();
        ifc.sample_en = 1'b0;
        chk("drop_sat", drop_cnt, 255);
        chk("stall_valid", ifc.out_valid, 1);

        // Reset with samples in flight.
        rst = 1'b1;
        step();
        chk("mrst_valid", ifc.out_valid, 0);
        chk("mrst_err",   err_cnt, 0);
        chk("mrst_drop",  drop_cnt, 0);
        rst = 1'b0;
        ifc.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mrst_nosample", ifc.out_valid, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
